// File: rtl/fiber_rx_deframer.sv
// Oversampling serial deframer for the inter-board fiber link: start/data/CRC-8/stop, link lock, error count.
// Optional build macro RX_INVERT_EN inverts rx_i ahead of the synchronizer for inverted transceivers.
module fiber_rx_deframer #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              crc_err_o,
    output logic              frame_err_o,
    output logic              link_ok_o,
    output logic [15:0]       err_cnt_o
);
    localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_W + 8);
    localparam int unsigned GC_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [PH_W-1:0]  PH_MID        = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0]  PH_MAX        = PH_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_CRC_LAST  = IDX_W'(7);
    localparam logic [GC_W-1:0]  GC_MAX        = GC_W'(LOCK_CNT);
    localparam logic [TO_W-1:0]  TO_MAX        = TO_W'(TIMEOUT);
    localparam logic [7:0]       CRC_POLY      = 8'h07;
    localparam logic [15:0]      ERR_SAT       = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PH_W-1:0]   r_ph;
    logic [PH_W-1:0]   w_ph_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;

    logic              w_rx_pin;
    logic              r_sync1;
    logic              r_s_rx;
    logic              r_rx_prev;
    logic              w_edge;
    logic              w_fall;
    logic              w_sample;

    logic [DATA_W-1:0] r_shift;
    logic [7:0]        r_crc_calc;
    logic [7:0]        r_crc_rx;
    logic              w_crc_fb;
    logic [7:0]        w_crc_step;
    logic              w_crc_match;

    logic              w_frame_begin;
    logic              w_shift_data;
    logic              w_shift_crc;
    logic              w_good;
    logic              w_crc_bad;
    logic              w_frm_bad;
    logic              w_err;

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_crc_err;
    logic              r_frame_err;
    logic [GC_W-1:0]   r_good_cnt;
    logic [GC_W-1:0]   w_gc_nxt;
    logic              r_link_ok;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_nxt;
    logic              w_timeout;
    logic [15:0]       r_err_cnt;

`ifdef RX_INVERT_EN
    assign w_rx_pin = ~rx_i;
`else
    assign w_rx_pin = rx_i;
`endif

    // Two-flop synchronizer plus one history flop for edge detection; all preset to line idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1   <= 1'b1;
            r_s_rx    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= w_rx_pin;
            r_s_rx    <= r_sync1;
            r_rx_prev <= r_s_rx;
        end
    end

    assign w_edge   = r_s_rx ^ r_rx_prev;
    assign w_fall   = r_rx_prev & ~r_s_rx;
    assign w_sample = (r_ph == PH_MID);

    assign w_crc_fb    = r_crc_calc[7] ^ r_s_rx;
    assign w_crc_step  = {r_crc_calc[6:0], 1'b0} ^ (w_crc_fb ? CRC_POLY : 8'h00);
    assign w_crc_match = (r_crc_rx == r_crc_calc);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_ph    <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state, phase tracking and per-sample strobes.
    always_comb begin
        w_state_nxt   = r_state;
        w_ph_nxt      = r_ph;
        w_idx_nxt     = r_idx;
        w_frame_begin = 1'b0;
        w_shift_data  = 1'b0;
        w_shift_crc   = 1'b0;
        w_good        = 1'b0;
        w_crc_bad     = 1'b0;
        w_frm_bad     = 1'b0;

        // Every line transition inside a frame realigns the bit phase.
        if (r_state != ST_IDLE) begin
            if (w_edge || (r_ph == PH_MAX)) begin
                w_ph_nxt = '0;
            end else begin
                w_ph_nxt = r_ph + PH_W'(1);
            end
        end

        unique case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_ph_nxt    = '0;
                end
            end
            ST_START: begin
                if (w_sample) begin
                    if (r_s_rx) begin
                        w_frm_bad   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_frame_begin = 1'b1;
                        w_idx_nxt     = '0;
                        w_state_nxt   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_sample) begin
                    w_shift_data = 1'b1;
                    if (r_idx == IDX_DATA_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_CRC;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_CRC: begin
                if (w_sample) begin
                    w_shift_crc = 1'b1;
                    if (r_idx == IDX_CRC_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (w_sample) begin
                    // A bad stop bit outranks the CRC verdict.
                    if (!r_s_rx) begin
                        w_frm_bad = 1'b1;
                    end else if (w_crc_match) begin
                        w_good = 1'b1;
                    end else begin
                        w_crc_bad = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Payload and CRC shift registers, LSB first on the wire.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_shift    <= '0;
            r_crc_calc <= '0;
            r_crc_rx   <= '0;
        end else begin
            if (w_frame_begin) begin
                r_crc_calc <= '0;
            end else if (w_shift_data) begin
                r_crc_calc <= w_crc_step;
            end
            if (w_shift_data) begin
                r_shift <= {r_s_rx, r_shift[DATA_W-1:1]};
            end
            if (w_shift_crc) begin
                r_crc_rx <= {r_s_rx, r_crc_rx[7:1]};
            end
        end
    end

    // Link lock bookkeeping: errors and timeout both drop the lock.
    always_comb begin
        w_err    = w_crc_bad | w_frm_bad;
        w_to_nxt = r_to_cnt;
        if (w_good) begin
            w_to_nxt = '0;
        end else if (r_to_cnt != TO_MAX) begin
            w_to_nxt = r_to_cnt + TO_W'(1);
        end
        w_timeout = (w_to_nxt == TO_MAX);
        w_gc_nxt  = r_good_cnt;
        if (w_err || w_timeout) begin
            w_gc_nxt = '0;
        end else if (w_good && (r_good_cnt != GC_MAX)) begin
            w_gc_nxt = r_good_cnt + GC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_good_cnt  <= '0;
            r_link_ok   <= 1'b0;
            r_to_cnt    <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_valid     <= w_good;
            r_crc_err   <= w_crc_bad;
            r_frame_err <= w_frm_bad;
            if (w_good) begin
                r_data <= r_shift;
            end
            r_good_cnt <= w_gc_nxt;
            r_link_ok  <= (w_gc_nxt == GC_MAX);
            r_to_cnt   <= w_to_nxt;
            if (w_err && (r_err_cnt != ERR_SAT)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign crc_err_o   = r_crc_err;
    assign frame_err_o = r_frame_err;
    assign link_ok_o   = r_link_ok;
    assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_fiber_rx_deframer.sv
// Scoreboard bench for fiber_rx_deframer: frames driven as a timed serial line, outcomes queued and matched.
module tb_fiber_rx_deframer;
    localparam int unsigned OS   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned LOCK = 4;
    localparam int unsigned TMO  = 4096;

    localparam longint CLK_T = 100000;
    localparam longint BIT_T = OS * CLK_T;
    localparam longint PPM_T = BIT_T / 10000;
    // Cycles from the start bit driven at a negedge to the valid_o sample.
    localparam longint LAT   = 2 + (DW + 9) * OS + OS / 2 + 1;

`ifdef RX_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    localparam int K_GOOD  = 0;
    localparam int K_CRC   = 1;
    localparam int K_FRAME = 2;
    localparam int K_MULTI = 9;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [15:0] errs;
        logic        link;
        longint      cyc;
    } obs_t;

    logic          clk;
    logic          rst_n;
    logic          rx;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          crc_err_o;
    logic          frame_err_o;
    logic          link_ok_o;
    logic [15:0]   err_cnt_o;

    exp_t          exp_q[$];
    obs_t          obs_q[$];
    obs_t          mon_o;
    longint        cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            exp_errs = 0;
    logic [31:0]   last_good = 32'h0;

    fiber_rx_deframer #(
        .OVERSAMPLE(OS),
        .DATA_W    (DW),
        .LOCK_CNT  (LOCK),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .rx_i       (rx),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .crc_err_o  (crc_err_o),
        .frame_err_o(frame_err_o),
        .link_ok_o  (link_ok_o),
        .err_cnt_o  (err_cnt_o)
    );

    initial clk = 1'b0;
    always #(CLK_T / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse with the status seen alongside it.
    always @(negedge clk) begin
        if (rst_n && (valid_o || crc_err_o || frame_err_o)) begin
            if ((32'(valid_o) + 32'(crc_err_o) + 32'(frame_err_o)) > 1) mon_o.kind = K_MULTI;
            else if (valid_o)   mon_o.kind = K_GOOD;
            else if (crc_err_o) mon_o.kind = K_CRC;
            else                mon_o.kind = K_FRAME;
            mon_o.data = data_o;
            mon_o.errs = err_cnt_o;
            mon_o.link = link_ok_o;
            mon_o.cyc  = cyc;
            obs_q.push_back(mon_o);
        end
    end

    initial begin
        #(CLK_T * 60000);
        $display("FAIL watchdog: simulation time limit reached, required tests to complete");
        $fatal(1);
    end

    // CRC-8 (x^8+x^2+x+1) by long division; first transmitted bit is the top coefficient.
    function automatic logic [7:0] crc8(input logic [31:0] d);
        logic [39:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) m[39-i] = d[i];
        for (int j = 39; j >= 8; j--) begin
            if (m[j]) m[j -: 9] = m[j -: 9] ^ 9'h107;
        end
        return m[7:0];
    endfunction

    task automatic drive(input logic b);
        rx = b ^ INV;
    endtask

    task automatic send_frame(input logic [31:0] d, input logic [7:0] flip, input logic stop_b,
                              input longint bit_t, input int kind, input logic [31:0] exp_data,
                              output longint t0);
        logic [7:0] c;
        exp_t       e;
        c      = crc8(d) ^ flip;
        e.kind = kind;
        e.data = exp_data;
        exp_q.push_back(e);
        t0 = cyc;
        drive(1'b0);
        #(bit_t);
        for (int i = 0; i < 32; i++) begin
            drive(d[i]);
            #(bit_t);
        end
        for (int i = 0; i < 8; i++) begin
            drive(c[i]);
            #(bit_t);
        end
        drive(stop_b);
        #(bit_t);
        drive(1'b1);
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= n) break;
            @(posedge clk);
        end
        if (obs_q.size() >= n) ok = 1'b1;
    endtask

    task automatic flush();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1);
        repeat (5) @(negedge clk);
        n_chk++;
        if ({data_o, valid_o, crc_err_o, frame_err_o, link_ok_o, err_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h v=%b c=%b f=%b l=%b e=%0d, required all 0",
                     data_o, valid_o, crc_err_o, frame_err_o, link_ok_o, err_cnt_o);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_good();
        longint t0;
        bit     ok;
        exp_t   e;
        obs_t   o;
        @(negedge clk);
        send_frame(32'hDEADBEEF, 8'h00, 1'b1, BIT_T, K_GOOD, 32'hDEADBEEF, t0);
        wait_obs(1, 100, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_timeout: %0d events, required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o.kind !== e.kind) begin n_fail++; $display("FAIL single_kind: got %0d required %0d", o.kind, e.kind); end
            n_chk++;
            if (o.data !== e.data) begin n_fail++; $display("FAIL single_data: got %h required %h", o.data, e.data); end
            n_chk++;
            if ((o.cyc - t0) !== LAT) begin n_fail++; $display("FAIL single_latency: got %0d required %0d", o.cyc - t0, LAT); end
            n_chk++;
            if (o.errs !== 16'd0) begin n_fail++; $display("FAIL single_errs: got %0d required 0", o.errs); end
        end
        last_good = 32'hDEADBEEF;
        repeat (20) @(posedge clk);
        n_chk++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL single_extra: %0d extra events, required 0", obs_q.size()); end
        flush();
    endtask

    task automatic test_crc_err();
        longint t0;
        bit     ok;
        exp_t   e;
        obs_t   o;
        @(negedge clk);
        send_frame(32'hDEADBEEF, 8'h08, 1'b1, BIT_T, K_CRC, last_good, t0);
        exp_errs++;
        wait_obs(1, 100, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL crc_timeout: %0d events, required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o.kind !== e.kind) begin n_fail++; $display("FAIL crc_kind: got %0d required %0d", o.kind, e.kind); end
            n_chk++;
            if (o.data !== e.data) begin n_fail++; $display("FAIL crc_data_held: got %h required %h", o.data, e.data); end
            n_chk++;
            if (o.errs !== 16'(exp_errs)) begin n_fail++; $display("FAIL crc_errs: got %0d required %0d", o.errs, exp_errs); end
            n_chk++;
            if (o.link !== 1'b0) begin n_fail++; $display("FAIL crc_link: got %b required 0", o.link); end
        end
        repeat (20) @(posedge clk);
        n_chk++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL crc_extra: %0d extra events, required 0", obs_q.size()); end
        flush();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pat [4];
        longint      t0;
        longint      cv;
        longint      tfall;
        bit          ok;
        exp_t        e;
        obs_t        o;
        pat[0] = 32'h12345678;
        pat[1] = 32'h00000000;
        pat[2] = 32'hFFFFFFFF;
        pat[3] = 32'hA5A55A5A;
        cv = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send_frame(pat[i], 8'h00, 1'b1, (i % 2 == 0) ? BIT_T + PPM_T : BIT_T - PPM_T, K_GOOD, pat[i], t0);
        end
        wait_obs(4, 100, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_timeout: %0d events, required 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_chk++;
                if (o.kind !== e.kind) begin n_fail++; $display("FAIL b2b_kind[%0d]: got %0d required %0d", i, o.kind, e.kind); end
                n_chk++;
                if (o.data !== e.data) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h required %h", i, o.data, e.data); end
                n_chk++;
                if (o.link !== (i == 3)) begin n_fail++; $display("FAIL b2b_link[%0d]: got %b required %b", i, o.link, i == 3); end
                cv = o.cyc;
            end
        end
        last_good = pat[3];
        flush();
        // Idle line: lock must survive TIMEOUT-6 cycles and drop exactly TIMEOUT after the last valid.
        while (cyc < cv + longint'(TMO) - 6) @(negedge clk);
        n_chk++;
        if (link_ok_o !== 1'b1) begin n_fail++; $display("FAIL timeout_early: link_ok=%b required 1", link_ok_o); end
        tfall = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (link_ok_o === 1'b0) begin
                tfall = cyc;
                break;
            end
        end
        n_chk++;
        if ((tfall - cv) !== longint'(TMO)) begin
            n_fail++;
            $display("FAIL timeout_drop: link_ok fell %0d cycles after valid, required %0d", tfall - cv, TMO);
        end
    endtask

    task automatic test_glitch();
        bit   ok;
        exp_t e;
        obs_t o;
        @(negedge clk);
        e.kind = K_FRAME;
        e.data = last_good;
        exp_q.push_back(e);
        exp_errs++;
        drive(1'b0);
        repeat (2) @(negedge clk);
        drive(1'b1);
        wait_obs(1, 40, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL glitch_timeout: %0d events, required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o.kind !== e.kind) begin n_fail++; $display("FAIL glitch_kind: got %0d required %0d", o.kind, e.kind); end
            n_chk++;
            if (o.errs !== 16'(exp_errs)) begin n_fail++; $display("FAIL glitch_errs: got %0d required %0d", o.errs, exp_errs); end
        end
        repeat (20) @(posedge clk);
        n_chk++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_extra: %0d extra events, required 0", obs_q.size()); end
        flush();
    endtask

    task automatic test_stop_zero();
        longint t0;
        bit     ok;
        exp_t   e;
        obs_t   o;
        @(negedge clk);
        send_frame(32'h0F0F1234, 8'h00, 1'b0, BIT_T, K_FRAME, last_good, t0);
        exp_errs++;
        wait_obs(1, 100, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stop0_timeout: %0d events, required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o.kind !== e.kind) begin n_fail++; $display("FAIL stop0_kind: got %0d required %0d", o.kind, e.kind); end
            n_chk++;
            if (o.data !== e.data) begin n_fail++; $display("FAIL stop0_data_held: got %h required %h", o.data, e.data); end
            n_chk++;
            if (o.errs !== 16'(exp_errs)) begin n_fail++; $display("FAIL stop0_errs: got %0d required %0d", o.errs, exp_errs); end
        end
        repeat (20) @(posedge clk);
        flush();
    endtask

    task automatic test_stuck_low();
        bit   ok;
        exp_t e;
        obs_t o;
        @(negedge clk);
        e.kind = K_FRAME;
        e.data = last_good;
        exp_q.push_back(e);
        exp_errs++;
        drive(1'b0);
        wait_obs(1, 500, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stuck_timeout: %0d events, required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o.kind !== e.kind) begin n_fail++; $display("FAIL stuck_kind: got %0d required %0d", o.kind, e.kind); end
            n_chk++;
            if (o.errs !== 16'(exp_errs)) begin n_fail++; $display("FAIL stuck_errs: got %0d required %0d", o.errs, exp_errs); end
        end
        repeat (600) @(posedge clk);
        n_chk++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL stuck_repeat: %0d extra events, required 0", obs_q.size()); end
        drive(1'b1);
        repeat (20) @(posedge clk);
        flush();
    endtask

    task automatic test_lsb_word();
        longint t0;
        bit     ok;
        exp_t   e;
        obs_t   o;
        @(negedge clk);
        send_frame(32'h00000001, 8'h00, 1'b1, BIT_T, K_GOOD, 32'h00000001, t0);
        wait_obs(1, 100, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL lsb_timeout: %0d events, required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o.kind !== e.kind) begin n_fail++; $display("FAIL lsb_kind: got %0d required %0d", o.kind, e.kind); end
            n_chk++;
            if (o.data !== e.data) begin n_fail++; $display("FAIL lsb_data: got %h required %h", o.data, e.data); end
        end
        last_good = 32'h00000001;
        repeat (20) @(posedge clk);
        flush();
    endtask

    task automatic test_reset_mid_frame();
        longint t0;
        bit     ok;
        exp_t   e;
        obs_t   o;
        @(negedge clk);
        drive(1'b0);
        #(BIT_T);
        for (int i = 0; i < 12; i++) begin
            drive(i[0]);
            #(BIT_T);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({data_o, valid_o, crc_err_o, frame_err_o, link_ok_o, err_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: data=%h v=%b c=%b f=%b l=%b e=%0d, required all 0",
                     data_o, valid_o, crc_err_o, frame_err_o, link_ok_o, err_cnt_o);
        end
        drive(1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_chk++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL midreset_spurious: %0d events, required 0", obs_q.size()); end
        flush();
        send_frame(32'hCAFE0042, 8'h00, 1'b1, BIT_T, K_GOOD, 32'hCAFE0042, t0);
        wait_obs(1, 100, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midreset_timeout: %0d events, required 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o.kind !== e.kind) begin n_fail++; $display("FAIL midreset_kind: got %0d required %0d", o.kind, e.kind); end
            n_chk++;
            if (o.data !== e.data) begin n_fail++; $display("FAIL midreset_data: got %h required %h", o.data, e.data); end
            n_chk++;
            if (o.errs !== 16'd0) begin n_fail++; $display("FAIL midreset_errs: got %0d required 0", o.errs); end
        end
        repeat (20) @(posedge clk);
        flush();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1);
        test_reset();
        test_single_good();
        test_crc_err();
        test_back_to_back();
        test_glitch();
        test_stop_zero();
        test_stuck_low();
        test_lsb_word();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
